rx_pipe_arbiter: RTL and testbench
==================================

// Module: rx_pipe_arbiter
// PURPOSE
// - Shares one pipe-write port between two rx_fifo output streams (one per MAC RX path), frame-granular.
// - Grant is held for a whole frame; round-robin between frames; a status trailer word is appended per frame.
// - Sits between the rx_fifo entry outputs ({last,keep,data} words) and the pipe to the NIC core.
// - A watchdog aborts frames whose source stalls mid-frame.
// PARAMETERS
// - N        32   data width; must be >= 32 (trailer layout)
// - S        4    keep width (N/8)
// - D        37   entry width = N+S+1, packed {last, keep[S-1:0], data[N-1:0]}
// - TIMEOUT  1024 idle cycles (granted source valid=0 mid-frame) before abort; >= 2
// PORTS
// - clk              in   1  clock; all logic on rising edge
// - reset            in   1  synchronous, active-high
// - s0_data          in   D  source-0 entry {last,keep,data}
// - s0_valid         in   1  source-0 entry valid
// - s0_ready         out  1  source-0 entry accepted when valid&&ready at clk edge
// - s0_err           in   1  source-0 frame error (tuser); sampled only with last entry
// - s1_data/s1_valid/s1_ready/s1_err   same as s0 for source 1
// - pipe_write_data  out  D  output word {last,keep,data}
// - pipe_write_req   out  1  output word valid
// - pipe_write_ack   in   1  word transferred at clk edge where req&&ack
// - grant            out  1  source currently/last granted
// - busy             out  1  state != IDLE
// BEHAVIOUR
// - Reset: pipe_write_req=0, pipe_write_data=0, s*_ready=0, grant=1, busy=0, state=IDLE, byte/timeout
//   counters=0, both 8-bit sequence counters=0. A partial frame is lost; no trailer.
// - Output register: one entry. Loadable when !req || ack (same-edge refill allowed, no bubble).
//   req/data held stable while req&&!ack. ack while req=0 is ignored.
// - Source-to-pipe latency: 1 cycle (word accepted at edge k -> req/data visible after edge k).
// - FSM:
//   - IDLE: if exactly one valid, grant it. If both valid, grant !grant (round-robin); source 0 wins first
//     after reset. ready=0 in IDLE. Go to XFER; clear bytes, clear tcnt.
//   - XFER: granted ready = (!req || ack); other ready=0.
//     - Accepted word forwarded with last forced 0, keep and data unchanged.
//     - bytes += popcount(keep), saturating at 0xFFFF.
//     - tcnt resets on each accepted word; increments when granted valid=0 (ack stalls do not count).
//     - Accepted word with last=1: latch err <= s_err, abort <= 0, go STATUS.
//     - tcnt == TIMEOUT-1 with valid=0: abort <= 1, err <= 0, go STATUS.
//   - STATUS: ready=0. When output register loadable, load trailer, seq[grant]++ (8-bit wrap).
//     Then go FLUSH if abort, else IDLE.
//   - FLUSH: granted ready=1; entries discarded, not forwarded. On accepted last=1 go IDLE.
// - Trailer word: last=1, keep=0.
//   - data[15:0] = bytes
//   - data[16]   = err
//   - data[17]   = abort
//   - data[18]   = grant (source id)
//   - data[23:19] = 0
//   - data[31:24] = seq[grant] before increment
//   - data[N-1:32] = 0
// - Data words always have keep != 0; keep=0 identifies the trailer.
// - Zero-length frames do not occur (the last entry always carries keep != 0).
// - Non-granted source is never accepted and never aborted; it waits.
// TESTING
// 1. Single frame: s0 words keep F,F,3, last on 3rd, err=0, ack=1.
//    -> 3 data words (last=0), then trailer data=0x0000_000A, last=1, keep=0; then req=0.
// 2. Fairness: s0 and s1 both valid from reset, 2-word frames back-to-back.
//    -> order s0,s1,s0,s1; trailer seq fields 0,0,1,1; bit18 = 0,1,0,1.
// 3. Backpressure: ack=0 for 5 cycles mid-frame.
//    -> req/data stable; s0_ready=0; after ack=1 all words appear once, in order, no bubble when ack held.
// 4. Error: s1 frame keep F,1 with s1_err=1 on last.
//    -> trailer bytes=5, bit16=1, bit18=1.
// 5. Timeout, TIMEOUT=8: s0 sends 2 keep-F words, then valid=0 for 8 cycles.
//    -> trailer bytes=8, bit17=1. Resumed s0 words until last are dropped; pending s1 frame served next.
// 6. Reset mid-frame -> req=0, ready=0 after the reset edge; the next frame's trailer has seq=0.

Source files
------------

// File: rtl/rx_pipe_arbiter_if.sv
// Bundle of the two rx_fifo entry streams and the single pipe-write port
// shared by rx_pipe_arbiter. The arbiter uses the master view; whatever
// drives the sources and consumes the pipe uses the slave view.
interface rx_pipe_arbiter_if #(
  parameter int N = 32,
  parameter int S = 4,
  parameter int D = 37
);
  logic [D-1:0] s0_data;
  logic         s0_valid;
  logic         s0_ready;
  logic         s0_err;
  logic [D-1:0] s1_data;
  logic         s1_valid;
  logic         s1_ready;
  logic         s1_err;
  logic [D-1:0] pipe_write_data;
  logic         pipe_write_req;
  logic         pipe_write_ack;
  logic         grant;
  logic         busy;

  modport master (
    input  s0_data, s0_valid, s0_err,
    input  s1_data, s1_valid, s1_err,
    input  pipe_write_ack,
    output s0_ready, s1_ready,
    output pipe_write_data, pipe_write_req,
    output grant, busy
  );

  modport slave (
    output s0_data, s0_valid, s0_err,
    output s1_data, s1_valid, s1_err,
    output pipe_write_ack,
    input  s0_ready, s1_ready,
    input  pipe_write_data, pipe_write_req,
    input  grant, busy
  );
endinterface

// File: rtl/rx_pipe_arbiter.sv
// Frame-granular round-robin arbiter merging two rx_fifo entry streams onto
// one pipe-write port. Each forwarded frame is followed by a status trailer
// (byte count, error, abort, source id, per-source sequence number). A
// watchdog aborts a granted frame whose source goes quiet mid-frame; the
// rest of that frame is then drained and discarded.
module rx_pipe_arbiter #(
  parameter int N       = 32,
  parameter int S       = 4,
  parameter int D       = 37,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  rx_pipe_arbiter_if.master  bus
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, XFER, STATUS, FLUSH} state_t;

  state_t       state;
  logic         grant_q;
  logic [D-1:0] word_p0;
  logic         vld_p0;
  logic [15:0]  bytes;
  logic [TW-1:0] tcnt;
  logic [7:0]   seq0;
  logic [7:0]   seq1;
  logic         err;
  logic         abort;

  logic         load_ok;
  logic [D-1:0] sel_data;
  logic         sel_valid;
  logic         sel_err;
  logic         sel_ready;
  logic         sel_last;
  logic [S-1:0] sel_keep;
  logic [N-1:0] sel_dat;
  logic         acc;
  logic [7:0]   seq_cur;

  function automatic logic [15:0] popcount(input logic [S-1:0] k);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < S; i++) c = c + 16'(k[i]);
    return c;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [D-1:0] trailer(input logic [15:0] nbytes, input logic e,
                                           input logic ab, input logic g,
                                           input logic [7:0] sq);
    logic [N-1:0] t;
    t        = '0;
    t[15:0]  = nbytes;
    t[16]    = e;
    t[17]    = ab;
    t[18]    = g;
    t[31:24] = sq;
    return {1'b1, {S{1'b0}}, t};
  endfunction

  // The output register can take a new word when empty or draining this edge.
  assign load_ok   = !vld_p0 || bus.pipe_write_ack;
  assign sel_data  = grant_q ? bus.s1_data  : bus.s0_data;
  assign sel_valid = grant_q ? bus.s1_valid : bus.s0_valid;
  assign sel_err   = grant_q ? bus.s1_err   : bus.s0_err;
  assign sel_last  = sel_data[D-1];
  assign sel_keep  = sel_data[N+S-1:N];
  assign sel_dat   = sel_data[N-1:0];
  assign seq_cur   = grant_q ? seq1 : seq0;

  // Ready follows ack combinationally so a held ack streams with no bubble;
  // in FLUSH the granted source is drained unconditionally.
  assign sel_ready = ((state == XFER) && load_ok) || (state == FLUSH);
  assign acc       = sel_valid && sel_ready;

  assign bus.s0_ready        = sel_ready && !grant_q;
  assign bus.s1_ready        = sel_ready &&  grant_q;
  assign bus.pipe_write_data = word_p0;
  assign bus.pipe_write_req  = vld_p0;
  assign bus.grant           = grant_q;
  assign bus.busy            = (state != IDLE);

  // Arbitration FSM, output register, byte/timeout counters and sequence numbers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= 1'b1;
      word_p0 <= '0;
      vld_p0  <= 1'b0;
      bytes   <= '0;
      tcnt    <= '0;
      seq0    <= '0;
      seq1    <= '0;
      err     <= 1'b0;
      abort   <= 1'b0;
    end else begin
      if (vld_p0 && bus.pipe_write_ack) vld_p0 <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.s0_valid || bus.s1_valid) begin
            grant_q <= (bus.s0_valid && bus.s1_valid) ? !grant_q : bus.s1_valid;
            bytes   <= '0;
            tcnt    <= '0;
            state   <= XFER;
          end
        end

        XFER: begin
          if (acc) begin
            vld_p0  <= 1'b1;
            word_p0 <= {1'b0, sel_keep, sel_dat};
            bytes   <= sat_add16(bytes, popcount(sel_keep));
            tcnt    <= '0;
            if (sel_last) begin
              err   <= sel_err;
              abort <= 1'b0;
              state <= STATUS;
            end
          end else if (!sel_valid) begin
            if (tcnt == TW'(TIMEOUT - 1)) begin
              abort <= 1'b1;
              err   <= 1'b0;
              state <= STATUS;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end

        STATUS: begin
          if (load_ok) begin
            vld_p0  <= 1'b1;
            word_p0 <= trailer(bytes, err, abort, grant_q, seq_cur);
            if (grant_q) seq1 <= seq1 + 8'd1;
            else         seq0 <= seq0 + 8'd1;
            state   <= abort ? FLUSH : IDLE;
          end
        end

        FLUSH: begin
          if (acc && sel_last) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_pipe_arbiter.sv
// Directed bench for rx_pipe_arbiter: single frame, fairness, backpressure,
// error trailer, watchdog abort with flush, and reset mid-frame.
module tb_rx_pipe_arbiter;
  localparam int N = 32;
  localparam int S = 4;
  localparam int D = 37;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic [D-1:0] got[$];
  int           got_cyc[$];

  always #5 clk = ~clk;

  rx_pipe_arbiter_if #(.N(N), .S(S), .D(D)) bus ();

  rx_pipe_arbiter #(.N(N), .S(S), .D(D), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every word transferred on the pipe (ack/req stable at negedge).
  always @(negedge clk) begin
    if (!reset && bus.pipe_write_req && bus.pipe_write_ack) begin
      got.push_back(bus.pipe_write_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [D-1:0] dw(input logic [S-1:0] k, input logic [N-1:0] d);
    return {1'b0, k, d};
  endfunction

  task automatic drive(input int src, input logic v, input logic [D-1:0] d, input logic e);
    if (src == 0) begin
      bus.s0_valid = v; bus.s0_data = d; bus.s0_err = e;
    end else begin
      bus.s1_valid = v; bus.s1_data = d; bus.s1_err = e;
    end
  endtask

  task automatic send_word(input int src, input logic [S-1:0] k, input logic [N-1:0] d,
                           input logic last, input logic e);
    logic rdy;
    drive(src, 1'b1, {last, k, d}, e);
    rdy = 1'b0;
    for (int n = 0; n < 200 && !rdy; n++) begin
      @(negedge clk);
      rdy = (src == 0) ? bus.s0_ready : bus.s1_ready;
    end
    if (!rdy) chk("send_timeout", 64'(rdy), 64'd1);
    step();
    drive(src, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_words(input int base, input int want, input string tag);
    for (int n = 0; n < 300 && (got.size() - base) < want; n++) step();
    repeat (5) step();
    chk(tag, 64'(got.size() - base), 64'(want));
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [D-1:0] exp);
    if (idx < got.size()) chk(tag, 64'(got[idx]), 64'(exp));
    else                  chk(tag, 64'hDEAD_BEEF_DEAD, 64'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int base;
    logic [D-1:0] e3[5];

    bus.s0_valid = 0; bus.s0_data = '0; bus.s0_err = 0;
    bus.s1_valid = 0; bus.s1_data = '0; bus.s1_err = 0;
    bus.pipe_write_ack = 1'b0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_req",   64'(bus.pipe_write_req), 64'd0);
    chk("rst_data",  64'(bus.pipe_write_data), 64'd0);
    chk("rst_rdy0",  64'(bus.s0_ready), 64'd0);
    chk("rst_rdy1",  64'(bus.s1_ready), 64'd0);
    chk("rst_grant", 64'(bus.grant), 64'd1);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    step();
    reset = 1'b0;
    bus.pipe_write_ack = 1'b1;

    // 1. Single frame from s0: keep F,F,3 -> bytes 10
    base = got.size();
    send_word(0, 4'hF, 32'h5000_0000, 1'b0, 1'b0);
    send_word(0, 4'hF, 32'h5000_0001, 1'b0, 1'b0);
    send_word(0, 4'h3, 32'h5000_0002, 1'b1, 1'b0);
    wait_words(base, 4, "t1_count");
    chk_word("t1_w0", base + 0, dw(4'hF, 32'h5000_0000));
    chk_word("t1_w1", base + 1, dw(4'hF, 32'h5000_0001));
    chk_word("t1_w2", base + 2, dw(4'h3, 32'h5000_0002));
    chk_word("t1_trl", base + 3, {1'b1, 4'h0, 32'h0000_000A});
    @(negedge clk);
    chk("t1_req_idle", 64'(bus.pipe_write_req), 64'd0);
    chk("t1_busy_idle", 64'(bus.busy), 64'd0);
    step();

    // 2. Fairness: both sources valid right after reset, 2-word frames
    do_reset();
    base = got.size();
    fork
      begin
        for (int f = 0; f < 2; f++) begin
          send_word(0, 4'hF, 32'h5000_0000 + 32'(f * 16), 1'b0, 1'b0);
          send_word(0, 4'hF, 32'h5000_0001 + 32'(f * 16), 1'b1, 1'b0);
        end
      end
      begin
        for (int f = 0; f < 2; f++) begin
          send_word(1, 4'hF, 32'h5000_0100 + 32'(f * 16), 1'b0, 1'b0);
          send_word(1, 4'hF, 32'h5000_0101 + 32'(f * 16), 1'b1, 1'b0);
        end
      end
    join
    wait_words(base, 12, "t2_count");
    chk_word("t2_a0", base + 0,  dw(4'hF, 32'h5000_0000));
    chk_word("t2_a1", base + 1,  dw(4'hF, 32'h5000_0001));
    chk_word("t2_at", base + 2,  {1'b1, 4'h0, 32'h0000_0008});
    chk_word("t2_b0", base + 3,  dw(4'hF, 32'h5000_0100));
    chk_word("t2_b1", base + 4,  dw(4'hF, 32'h5000_0101));
    chk_word("t2_bt", base + 5,  {1'b1, 4'h0, 32'h0004_0008});
    chk_word("t2_c0", base + 6,  dw(4'hF, 32'h5000_0010));
    chk_word("t2_c1", base + 7,  dw(4'hF, 32'h5000_0011));
    chk_word("t2_ct", base + 8,  {1'b1, 4'h0, 32'h0100_0008});
    chk_word("t2_d0", base + 9,  dw(4'hF, 32'h5000_0110));
    chk_word("t2_d1", base + 10, dw(4'hF, 32'h5000_0111));
    chk_word("t2_dt", base + 11, {1'b1, 4'h0, 32'h0104_0008});

    // 3. Backpressure: ack low for 5 cycles mid-frame
    do_reset();
    base = got.size();
    for (int i = 0; i < 4; i++) e3[i] = dw(4'hF, 32'h5000_0020 + 32'(i));
    e3[4] = {1'b1, 4'h0, 32'h0000_0010};
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_word(0, 4'hF, 32'h5000_0020 + 32'(i), (i == 3), 1'b0);
      end
      begin
        int idx;
        for (int k = 0; k < 200 && (got.size() - base) < 1; k++) @(negedge clk);
        step();
        bus.pipe_write_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          idx = got.size() - base;
          chk("t3_req_held", 64'(bus.pipe_write_req), 64'd1);
          if (idx < 5) chk("t3_data_held", 64'(bus.pipe_write_data), 64'(e3[idx]));
          else         chk("t3_data_held", 64'(idx), 64'd4);
          chk("t3_rdy_low", 64'(bus.s0_ready), 64'd0);
        end
        step();
        bus.pipe_write_ack = 1'b1;
      end
    join
    wait_words(base, 5, "t3_count");
    for (int i = 0; i < 5; i++) chk_word("t3_word", base + i, e3[i]);
    if (got_cyc.size() >= base + 5)
      chk("t3_span", 64'(got_cyc[base + 4] - got_cyc[base]), 64'd9);
    else
      chk("t3_span", 64'(got_cyc.size()), 64'(base + 5));

    // 4. Error frame from s1: keep F,1 with err on last -> bytes 5, err, id 1
    do_reset();
    base = got.size();
    send_word(1, 4'hF, 32'h5000_0130, 1'b0, 1'b0);
    send_word(1, 4'h1, 32'h5000_0131, 1'b1, 1'b1);
    wait_words(base, 3, "t4_count");
    chk_word("t4_w0", base + 0, dw(4'hF, 32'h5000_0130));
    chk_word("t4_w1", base + 1, dw(4'h1, 32'h5000_0131));
    chk_word("t4_trl", base + 2, {1'b1, 4'h0, 32'h0005_0005});
    chk("t4_grant", 64'(bus.grant), 64'd1);

    // 5. Watchdog abort on s0 (TIMEOUT=8), then s1 frame is served
    do_reset();
    base = got.size();
    fork
      begin
        send_word(0, 4'hF, 32'h5000_0040, 1'b0, 1'b0);
        send_word(0, 4'hF, 32'h5000_0041, 1'b0, 1'b0);
        repeat (4) step();
        @(negedge clk);
        chk("t5_s1_wait", 64'(bus.s1_ready), 64'd0);
        chk("t5_busy", 64'(bus.busy), 64'd1);
        repeat (8) step();
        send_word(0, 4'hF, 32'h5000_0042, 1'b0, 1'b0);
        send_word(0, 4'h3, 32'h5000_0043, 1'b1, 1'b0);
      end
      begin
        repeat (3) step();
        send_word(1, 4'hF, 32'h5000_0140, 1'b0, 1'b0);
        send_word(1, 4'hF, 32'h5000_0141, 1'b1, 1'b0);
      end
    join
    wait_words(base, 6, "t5_count");
    chk_word("t5_w0", base + 0, dw(4'hF, 32'h5000_0040));
    chk_word("t5_w1", base + 1, dw(4'hF, 32'h5000_0041));
    chk_word("t5_abort_trl", base + 2, {1'b1, 4'h0, 32'h0002_0008});
    chk_word("t5_s1_w0", base + 3, dw(4'hF, 32'h5000_0140));
    chk_word("t5_s1_w1", base + 4, dw(4'hF, 32'h5000_0141));
    chk_word("t5_s1_trl", base + 5, {1'b1, 4'h0, 32'h0004_0008});

    // 6. Reset mid-frame clears output and sequence numbers
    do_reset();
    base = got.size();
    send_word(0, 4'hF, 32'h5000_0050, 1'b1, 1'b0);
    wait_words(base, 2, "t6_first_count");
    chk_word("t6_first_trl", base + 1, {1'b1, 4'h0, 32'h0000_0004});
    send_word(0, 4'hF, 32'h5000_0051, 1'b0, 1'b0);
    bus.pipe_write_ack = 1'b0;
    @(negedge clk);
    chk("t6_pre_req", 64'(bus.pipe_write_req), 64'd1);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("t6_rst_req",   64'(bus.pipe_write_req), 64'd0);
    chk("t6_rst_rdy0",  64'(bus.s0_ready), 64'd0);
    chk("t6_rst_rdy1",  64'(bus.s1_ready), 64'd0);
    chk("t6_rst_busy",  64'(bus.busy), 64'd0);
    chk("t6_rst_grant", 64'(bus.grant), 64'd1);
    step();
    reset = 1'b0;
    bus.pipe_write_ack = 1'b1;
    base = got.size();
    send_word(0, 4'h3, 32'h5000_0052, 1'b1, 1'b0);
    wait_words(base, 2, "t6_next_count");
    chk_word("t6_next_w0", base + 0, dw(4'h3, 32'h5000_0052));
    chk_word("t6_next_trl", base + 1, {1'b1, 4'h0, 32'h0000_0002});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
